bus_arbiter_mux: RTL and testbench
==================================

Name: bus_arbiter_mux

Overview:
- Parametrised successor to the CPU's internal-bus source multiplexer.
- Selects one of NUM_SRC sources (general registers, PC, IR, MAR, memory, and extras) onto a registered DATA_W-bit bus.
- Selection comes from either a control-unit forced select or round-robin arbitration.
- Bus output uses a valid/ready handshake, so consumers can stall the bus without losing data.

Parameters:
- DATA_W, 8: bus and source data width.
- NUM_SRC, 5: number of sources, 2..8.
- SEL_W, 3: select/index width; must satisfy 2**SEL_W >= NUM_SRC.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- reset_n, input, 1: synchronous, active-low reset.
- src_req, input, NUM_SRC: per-source request; bit i = source i has data.
- src_data, input, NUM_SRC*DATA_W: flattened source data; source i occupies bits [i*DATA_W +: DATA_W].
- src_gnt, output, NUM_SRC: one-hot accept pulse; source i's data is captured at this edge.
- force_sel_valid, input, 1: control unit overrides arbitration.
- force_sel, input, SEL_W: forced source index.
- bus_data, output, DATA_W: registered bus word.
- bus_valid, output, 1: bus_data holds a valid word.
- bus_ready, input, 1: consumer accepts the word this cycle.
- bus_src, output, SEL_W: index of the source that produced bus_data.
- sel_err, output, 1: sticky flag; a forced index >= NUM_SRC was seen.

Behaviour:
- Reset (reset_n low at a clock edge):
  - bus_valid=0, bus_data=0, bus_src=0, sel_err=0.
  - Round-robin pointer last_gnt=NUM_SRC-1, so source 0 wins first.
  - src_gnt forced to 0 combinationally while reset_n is low.
  - Reset mid-stall discards the held word; no grant is issued that cycle.
- Output register load condition: load = !bus_valid || bus_ready. If load is 0, no grant is issued.
- Forced mode (force_sel_valid=1):
  - force_sel < NUM_SRC and src_req[force_sel]=1: grant force_sel.
  - force_sel < NUM_SRC and its request is low: no grant; no fallback to arbitration.
  - force_sel >= NUM_SRC: no grant; sel_err set on that edge and held until reset.
  - last_gnt is not updated by forced grants.
- Arbitration mode (force_sel_valid=0):
  - Round-robin search starts at last_gnt+1, wrapping at NUM_SRC-1 -> 0.
  - The first requesting source is granted; last_gnt updates to the winner.
- Grant:
  - src_gnt is combinational from req, force inputs, load and state: at most one bit high, only when load=1.
  - At the edge: bus_data <= winner's data, bus_src <= winner index, bus_valid <= 1.
- No grant with load=1: bus_valid <= 0 (the word was drained or the register was empty).
- Latency and throughput:
  - A request seen while the register is empty gives bus_valid=1 on the next cycle.
  - Sustains 1 word/cycle while bus_ready=1.
- Stall: while bus_valid=1 and bus_ready=0, bus_data and bus_src hold stable and src_gnt=0.
- Simultaneous drain and load: the new word replaces the old at the same edge; no bubble.
- Sources must hold src_data stable in the cycle their src_gnt is high.
- State summary:
  - EMPTY (bus_valid=0) -> FULL on grant.
  - FULL -> FULL on ready plus grant.
  - FULL -> EMPTY on ready with no grant.
  - FULL holds on !ready.

Optional Feature:
- Macro: BUS_HIZ_EN.
- Defined: bus_data drives all-z whenever bus_valid=0, including during reset, matching the legacy tri-state bus.
- Undefined: bus_data holds its register value, which is 0 after reset and the last word after a drain; no z is ever driven.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles, src_req=0 -> bus_valid=0, src_gnt=0, sel_err=0, bus_data=0 (or z with BUS_HIZ_EN).
- Round-robin fairness: NUM_SRC=5, src_req=5'b11111, bus_ready=1, source i data=8'h10+i, 6 cycles -> bus_src sequence 0,1,2,3,4,0; bus_data 10,11,12,13,14,10; one grant per cycle.
- Backpressure: grant source 2 (data 8'hA5), then bus_ready=0 for 3 cycles -> bus_data=A5 and bus_src=2 stable, src_gnt=0; bus_ready=1 -> next requester granted at the same edge.
- Forced select: force_sel_valid=1, force_sel=4, src_req=5'b10001 -> source 4 granted, last_gnt unchanged; then force_sel=3 with src_req[3]=0 -> no grant, bus_valid falls after drain.
- Bad select: force_sel=6 with NUM_SRC=5 -> no grant, sel_err=1 held until the next reset.
- Reset mid-stall: bus_valid=1, bus_ready=0, reset_n=0 for one edge -> bus_valid=0, pointer reset; next arbitration grants source 0 first.

Source files
------------

// File: rtl/bus_arbiter_mux.sv
// bus_arbiter_mux: selects one of NUM_SRC sources onto a registered bus word,
// either by control-unit forced select or round-robin arbitration, with a
// valid/ready output handshake.
// Optional macro BUS_HIZ_EN: bus_data floats (all z) whenever no valid word is held.
module bus_arbiter_mux #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_SRC = 5,
    parameter int unsigned SEL_W   = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_SRC-1:0]        src_req,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_gnt,
    input  logic                      force_sel_valid,
    input  logic [SEL_W-1:0]          force_sel,
    output logic [DATA_W-1:0]         bus_data,
    output logic                      bus_valid,
    input  logic                      bus_ready,
    output logic [SEL_W-1:0]          bus_src,
    output logic                      sel_err
);

    localparam int unsigned PAD = 1 << SEL_W;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_SRC - 1);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   data_q;
    logic [SEL_W-1:0]    last_gnt;
    logic [PAD-1:0]      req_pad;
    logic                load;
    logic                force_in_range;
    logic                force_ok;
    logic                arb_found;
    logic [SEL_W-1:0]    arb_idx;
    logic [SEL_W-1:0]    cand;
    logic                grant;
    logic [SEL_W-1:0]    win_idx;
    logic [DATA_W-1:0]   win_data;

    // Requests padded to the full index range so any SEL_W index is safe.
    assign req_pad        = PAD'(src_req);
    assign load           = (state == EMPTY) || bus_ready;
    assign force_in_range = 32'(force_sel) < NUM_SRC;
    assign force_ok       = force_in_range && req_pad[force_sel];
    assign bus_valid      = (state == FULL);

    // Round-robin search starting one past the last arbitrated winner.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = last_gnt;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + SEL_W'(1);
            if (!arb_found && req_pad[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Winner selection, one-hot grant and winner data mux.
    always_comb begin
        grant    = reset_n && load && (force_sel_valid ? force_ok : arb_found);
        win_idx  = force_sel_valid ? force_sel : arb_idx;
        win_data = '0;
        src_gnt  = '0;
        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            if (win_idx == SEL_W'(j)) begin
                win_data   = src_data[j*DATA_W +: DATA_W];
                src_gnt[j] = grant;
            end
        end
    end

    // Output register occupancy: fills on grant, drains on ready without grant.
    always_comb begin
        state_next = state;
        if (load) begin
            state_next = grant ? FULL : EMPTY;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Bus word, source index, round-robin pointer and sticky select error.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q   <= '0;
            bus_src  <= '0;
            last_gnt <= LAST_IDX;
            sel_err  <= 1'b0;
        end else begin
            if (grant) begin
                data_q  <= win_data;
                bus_src <= win_idx;
                if (!force_sel_valid) begin
                    last_gnt <= win_idx;
                end
            end
            if (force_sel_valid && !force_in_range) begin
                sel_err <= 1'b1;
            end
        end
    end

`ifdef BUS_HIZ_EN
    assign bus_data = (reset_n && bus_valid) ? data_q : 'z;
`else
    assign bus_data = data_q;
`endif

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Self-checking bench for bus_arbiter_mux: directed scenarios plus randomized
// traffic, all checked against a transaction-level reference model.
module tb_bus_arbiter_mux;

    localparam int N  = 5;
    localparam int DW = 8;
    localparam int SW = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      src_req;
    logic [N*DW-1:0]   src_data;
    logic [N-1:0]      src_gnt;
    logic              force_sel_valid;
    logic [SW-1:0]     force_sel;
    logic [DW-1:0]     bus_data;
    logic              bus_valid;
    logic              bus_ready;
    logic [SW-1:0]     bus_src;
    logic              sel_err;

    int errors = 0;
    int checks = 0;

    // Reference model: the bus word as a transaction, plus pointer and error flag.
    logic [DW-1:0] data_arr [N];
    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_src;
    int            m_last;
    bit            m_err;

    bus_arbiter_mux #(.DATA_W(DW), .NUM_SRC(N), .SEL_W(SW)) dut (
        .clk(clk), .reset_n(reset_n), .src_req(src_req), .src_data(src_data),
        .src_gnt(src_gnt), .force_sel_valid(force_sel_valid), .force_sel(force_sel),
        .bus_data(bus_data), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_src(bus_src), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N*DW-1:0] pack_data();
        logic [N*DW-1:0] f;
        for (int i = 0; i < N; i++) f[i*DW +: DW] = data_arr[i];
        return f;
    endfunction

    // One clock cycle: drive, check grant before the edge, update model, check outputs.
    task automatic cycle(input logic [N-1:0] req, input logic rdy, input logic fv,
                         input logic [SW-1:0] fs, input logic rn);
        int win;
        bit ld;
        logic [N-1:0] exp_gnt;
        logic [DW-1:0] exp_bus;
        src_req = req; bus_ready = rdy; force_sel_valid = fv; force_sel = fs;
        reset_n = rn; src_data = pack_data();
        #1;
        win = -1;
        ld  = !m_valid || rdy;
        if (rn && ld) begin
            if (fv) begin
                if (int'(fs) < N && req[fs]) win = int'(fs);
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int s;
                    s = (m_last + k) % N;
                    if (win < 0 && req[s]) win = s;
                end
            end
        end
        exp_gnt = '0;
        if (win >= 0) exp_gnt[win] = 1'b1;
        check("gnt", 32'(src_gnt), 32'(exp_gnt));
        @(posedge clk);
        if (!rn) begin
            m_valid = 0; m_data = '0; m_src = 0; m_last = N - 1; m_err = 0;
        end else begin
            if (fv && int'(fs) >= N) m_err = 1;
            if (ld) begin
                if (win >= 0) begin
                    m_valid = 1; m_data = data_arr[win]; m_src = win;
                    if (!fv) m_last = win;
                end else begin
                    m_valid = 0;
                end
            end
        end
        #1;
`ifdef BUS_HIZ_EN
        exp_bus = m_valid ? m_data : 'z;
`else
        exp_bus = m_data;
`endif
        check("valid", 32'(bus_valid), 32'(m_valid));
        check("data", 32'(bus_data), 32'(exp_bus));
        check("src", 32'(bus_src), 32'(m_src));
        check("sel_err", 32'(sel_err), 32'(m_err));
    endtask

    initial begin
        m_valid = 0; m_data = '0; m_src = 0; m_last = N - 1; m_err = 0;
        for (int i = 0; i < N; i++) data_arr[i] = 8'(8'h10 + i);

        // Reset then idle.
        cycle('0, 1'b1, 1'b0, '0, 1'b0);
        cycle('0, 1'b1, 1'b0, '0, 1'b0);
        check("rst_valid", 32'(bus_valid), 32'd0);
        check("rst_err", 32'(sel_err), 32'd0);
        cycle('0, 1'b1, 1'b0, '0, 1'b1);
        check("idle_gnt", 32'(src_gnt), 32'd0);

        // Round-robin fairness: 0,1,2,3,4,0 with data 10..14,10.
        for (int i = 0; i < 6; i++) begin
            cycle(5'b11111, 1'b1, 1'b0, '0, 1'b1);
            check("rr_src", 32'(bus_src), 32'(i % N));
            check("rr_data", 32'(bus_data), 32'(8'h10 + (i % N)));
        end

        // Backpressure: grant source 2 (A5), stall 3 cycles, then release.
        cycle('0, 1'b0, 1'b0, '0, 1'b0);
        data_arr[2] = 8'hA5;
        cycle(5'b00100, 1'b1, 1'b0, '0, 1'b1);
        check("bp_src", 32'(bus_src), 32'd2);
        for (int i = 0; i < 3; i++) begin
            cycle(5'b11111, 1'b0, 1'b0, '0, 1'b1);
            check("bp_hold", 32'(bus_data), 32'h0A5);
            check("bp_src_hold", 32'(bus_src), 32'd2);
        end
        cycle(5'b11111, 1'b1, 1'b0, '0, 1'b1);
        check("bp_next", 32'(bus_src), 32'd3);

        // Forced select, then forced select of a non-requesting source.
        cycle(5'b10001, 1'b1, 1'b1, 3'd4, 1'b1);
        check("force_src", 32'(bus_src), 32'd4);
        cycle(5'b10001, 1'b1, 1'b1, 3'd3, 1'b1);
        check("force_drain", 32'(bus_valid), 32'd0);
        cycle(5'b11111, 1'b1, 1'b0, '0, 1'b1);
        check("ptr_kept", 32'(bus_src), 32'd4);

        // Bad select: sticky until reset.
        cycle(5'b11111, 1'b1, 1'b1, 3'd6, 1'b1);
        check("bad_err", 32'(sel_err), 32'd1);
        cycle(5'b11111, 1'b1, 1'b0, '0, 1'b1);
        cycle(5'b11111, 1'b1, 1'b0, '0, 1'b1);
        check("bad_sticky", 32'(sel_err), 32'd1);

        // Reset mid-stall.
        cycle(5'b11111, 1'b0, 1'b0, '0, 1'b1);
        cycle(5'b11111, 1'b0, 1'b0, '0, 1'b0);
        check("rs_valid", 32'(bus_valid), 32'd0);
        check("rs_err", 32'(sel_err), 32'd0);
        cycle(5'b11111, 1'b1, 1'b0, '0, 1'b1);
        check("rs_first", 32'(bus_src), 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) data_arr[i] = 8'($urandom);
            cycle(5'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 39) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
